serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only when ready=1.
REQ-005 SHALL have port sub  input  1  mode select: 0 computes a+b, 1 computes a-b; sampled with start.
REQ-006 SHALL have ports a, b  input  WIDTH  operands; sampled with start.
REQ-007 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-008 SHALL have port sum  output  WIDTH  result of the last completed operation.
REQ-009 SHALL have port cout  output  1  carry out of the MSB. For subtract, 1 means no borrow (a >= b unsigned).
REQ-010 SHALL have port ovf  output  1  two's-complement signed overflow of the last operation.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking that sum/cout/ovf have just updated.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: ready=1. When start=1 at an edge, SHALL perform all of the following and enter RUN:
  - capture a into the A shift register;
  - capture b, or ~b when sub=1, into the B shift register;
  - load the carry flop with sub;
  - clear the bit counter.
REQ-014 SHALL process one bit per RUN cycle, LSB first, through one full-adder cell:
  - inputs: A[0], B[0], carry flop;
  - the sum bit shifts into the MSB of a working result register;
  - A and B shift right by one;
  - the carry flop takes the cell carry-out.
REQ-015 SHALL capture the carry into the MSB position (cell carry-in on the bit-counter = WIDTH-1 cycle) for the ovf calculation.
REQ-016 SHALL remain in RUN for exactly WIDTH cycles. On the edge where bit counter = WIDTH-1, SHALL:
  - load sum, cout and ovf (ovf = MSB carry-in XOR carry-out) from the final values;
  - enter DONE.
REQ-017 DONE: done=1 for exactly one cycle, ready=0; SHALL unconditionally return to IDLE on the next edge.
REQ-018 Latency: if start is accepted at edge k, sum/cout/ovf SHALL update and done SHALL rise at edge k+WIDTH; ready SHALL return high at edge k+WIDTH+1.
REQ-019 start SHALL be ignored (no effect, no queuing) whenever ready=0, i.e. in RUN and DONE.
REQ-020 sum, cout and ovf SHALL hold their values from done until the next operation completes; partial results SHALL never appear on them.
REQ-021 Bit counter width SHALL be clog2(WIDTH) and SHALL NOT wrap within an operation.
REQ-022 Throughput: at most one operation per WIDTH+1 cycles; back-to-back start held high SHALL restart at the first IDLE cycle.

Reset
REQ-023 While rst_n=0, SHALL asynchronously force:
  - state=IDLE, ready=1, done=0;
  - sum=0, cout=0, ovf=0;
  - shift registers, carry flop and bit counter to 0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation: no done pulse and no result update. The first edge after release SHALL be a normal IDLE cycle.

Structure
REQ-025 Package serial_adder_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-026 SHALL instantiate exactly one combinational sub-module full_adder_cell:
  - inputs: x, y, cin;
  - outputs: s, co;
  - the only arithmetic logic in the datapath.
REQ-027 All other logic SHALL be registers, FSM and counter; target 120-400 RTL lines.

Verification
REQ-028 WIDTH=8, add 200+100 -> done at k+8, sum=44, cout=1, ovf=0.
REQ-029 WIDTH=8, sub 5-7 -> sum=0xFE, cout=0, ovf=0; sub 7-5 -> sum=2, cout=1.
REQ-030 WIDTH=8, add 127+1 -> sum=0x80, ovf=1, cout=0; add 0x80+0x80 -> sum=0, ovf=1, cout=1.
REQ-031 Pulse start again at edges k+3 and k+8 of an active operation -> both ignored, exactly one done, result unchanged.
REQ-032 Assert rst_n low at edge k+4 of an operation -> ready=1, sum=0, no done; a fresh 3+4 then gives sum=7 at +8 cycles.
REQ-033 WIDTH=16 and WIDTH=2 random add/sub, 1000 ops -> sum/cout/ovf match a reference model, and done latency equals WIDTH every time.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit full adder; the only arithmetic in the serial datapath.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ cin;
    assign co = (x & y) | (cin & (x ^ y));

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one bit per cycle, LSB first, result published with a done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic cell_s;
    logic cell_co;

    full_adder_cell u_cell (
        .x   (a_sr_q[0]),
        .y   (b_sr_q[0]),
        .cin (carry_q),
        .s   (cell_s),
        .co  (cell_co)
    );

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: the +1 rides in on the carry flop.
                    a_sr_d  = a;
                    b_sr_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                res_d   = {cell_s, res_q[WIDTH-1:1]};
                carry_d = cell_co;
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB on this final cycle.
                    sum_d   = {cell_s, res_q[WIDTH-1:1]};
                    cout_d  = cell_co;
                    ovf_d   = carry_q ^ cell_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Randomised and directed checks of serial_adder at WIDTH 8, 16 and 2 against an arithmetic model.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v = '0;
    logic [2:0]  sub_v = '0;
    logic [63:0] a_in = '0;
    logic [63:0] b_in = '0;

    logic [7:0]  sum8;
    logic [15:0] sum16;
    logic [1:0]  sum2;
    logic [2:0]  ready_v, done_v, cout_v, ovf_v;

    int checks = 0;
    int errors = 0;
    int widths[3] = '{8, 16, 2};

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_v[0]),
        .a(a_in[7:0]), .b(b_in[7:0]), .ready(ready_v[0]), .sum(sum8),
        .cout(cout_v[0]), .ovf(ovf_v[0]), .done(done_v[0])
    );

    serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_v[1]),
        .a(a_in[15:0]), .b(b_in[15:0]), .ready(ready_v[1]), .sum(sum16),
        .cout(cout_v[1]), .ovf(ovf_v[1]), .done(done_v[1])
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_v[2]),
        .a(a_in[1:0]), .b(b_in[1:0]), .ready(ready_v[2]), .sum(sum2),
        .cout(cout_v[2]), .ovf(ovf_v[2]), .done(done_v[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sum_of(input int d);
        case (d)
            0:       return 64'(sum8);
            1:       return 64'(sum16);
            default: return 64'(sum2);
        endcase
    endfunction

    // Reference: unsigned result/carry and signed overflow from plain integer arithmetic.
    function automatic void ref_model(input int w, input bit s, input logic [63:0] ai, input logic [63:0] bi,
                                      output logic [63:0] r, output bit c, output bit o);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned ua = ai & mask;
        longint unsigned ub = bi & mask;
        longint unsigned t;
        longint sa, sb, sr, hi, lo;
        if (!s) begin
            t = ua + ub;
            r = t & mask;
            c = ((t >> w) & 64'd1) != 0;
        end else begin
            r = (ua - ub) & mask;
            c = (ua >= ub);
        end
        sa = ((ua >> (w - 1)) & 1) != 0 ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb = ((ub >> (w - 1)) & 1) != 0 ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        sr = s ? sa - sb : sa + sb;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        o  = (sr > hi) || (sr < lo);
    endfunction

    task automatic wait_ready(input int d);
        int n = 0;
        while (!ready_v[d] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_v[d]) check("ready_timeout", 64'(ready_v[d]), 64'd1);
    endtask

    task automatic do_op(input int d, input bit s, input logic [63:0] ai, input logic [63:0] bi);
        logic [63:0] prev, er;
        bit ec, eo;
        int lat = 0;
        wait_ready(d);
        prev = sum_of(d);
        @(negedge clk);
        a_in = ai; b_in = bi; sub_v[d] = s; start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        check("busy", 64'(ready_v[d]), 64'd0);
        while (!done_v[d] && lat < 200) begin
            check("sum_hold", sum_of(d), prev);
            @(posedge clk); #1;
            lat++;
        end
        ref_model(widths[d], s, ai, bi, er, ec, eo);
        check("latency", 64'(lat), 64'(widths[d]));
        check("sum", sum_of(d), er);
        check("cout", 64'(cout_v[d]), 64'(ec));
        check("ovf", 64'(ovf_v[d]), 64'(eo));
        @(posedge clk); #1;
        check("done_pulse", 64'(done_v[d]), 64'd0);
        check("ready_back", 64'(ready_v[d]), 64'd1);
    endtask

    initial begin
        int dones, done_edge, d1, d2;

        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_ready", 64'(ready_v[d]), 64'd1);
            check("rst_done", 64'(done_v[d]), 64'd0);
            check("rst_sum", sum_of(d), 64'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 1'b0, 64'd200, 64'd100);
        check("add200_100", sum_of(0), 64'd44);
        check("add200_100_c", 64'(cout_v[0]), 64'd1);
        do_op(0, 1'b1, 64'd5, 64'd7);
        check("sub5_7", sum_of(0), 64'hFE);
        check("sub5_7_c", 64'(cout_v[0]), 64'd0);
        do_op(0, 1'b1, 64'd7, 64'd5);
        check("sub7_5", sum_of(0), 64'd2);
        do_op(0, 1'b0, 64'd127, 64'd1);
        check("add127_1_ovf", 64'(ovf_v[0]), 64'd1);
        do_op(0, 1'b0, 64'h80, 64'h80);
        check("add80_80_ovf", 64'(ovf_v[0]), 64'd1);
        check("add80_80_c", 64'(cout_v[0]), 64'd1);

        // start pulses at edges k+3 and k+8 must be ignored
        wait_ready(0);
        @(negedge clk);
        a_in = 64'd200; b_in = 64'd100; sub_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        dones = 0; done_edge = -1;
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk);
            if (e == 3 || e == 8) begin
                start_v[0] = 1'b1; a_in = 64'd17; b_in = 64'd1; sub_v[0] = 1'b1;
            end
            @(posedge clk); #1;
            start_v[0] = 1'b0;
            if (done_v[0]) begin
                dones++;
                done_edge = e;
            end
        end
        check("ign_dones", 64'(dones), 64'd1);
        check("ign_edge", 64'(done_edge), 64'd8);
        check("ign_sum", sum_of(0), 64'd44);
        check("ign_ready", 64'(ready_v[0]), 64'd1);

        // reset mid-run
        do_op(0, 1'b0, 64'd9, 64'd9);
        @(negedge clk);
        a_in = 64'd100; b_in = 64'd50; sub_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(ready_v[0]), 64'd1);
        check("mid_rst_sum", sum_of(0), 64'd0);
        check("mid_rst_done", 64'(done_v[0]), 64'd0);
        check("mid_rst_cout", 64'(cout_v[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (done_v[0]) dones++;
        end
        check("mid_rst_nodone", 64'(dones), 64'd0);
        do_op(0, 1'b0, 64'd3, 64'd4);
        check("after_rst_3p4", sum_of(0), 64'd7);

        // start held high: second op accepted on the first IDLE cycle
        wait_ready(2);
        @(negedge clk);
        a_in = 64'd1; b_in = 64'd1; sub_v[2] = 1'b0; start_v[2] = 1'b1;
        @(posedge clk); #1;
        d1 = -1; d2 = -1;
        for (int e = 1; e <= 20 && d2 < 0; e++) begin
            @(posedge clk); #1;
            if (done_v[2]) begin
                if (d1 < 0) d1 = e;
                else d2 = e;
            end
        end
        @(negedge clk);
        start_v[2] = 1'b0;
        check("b2b_first", 64'(d1), 64'd2);
        check("b2b_second", 64'(d2), 64'd6);

        for (int i = 0; i < 1000; i++)
            do_op(1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
        for (int i = 0; i < 1000; i++)
            do_op(2, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
        for (int i = 0; i < 200; i++)
            do_op(0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder
